// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imem_pkg;

    // Instruction memory geometry, also used by the fetch stage for indexing.
    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;
    localparam int INSTR_BYTES = 4;

    // Width of the byte-lane counter inside one instruction word.
    localparam int LANE_W = $clog2(INSTR_BYTES);

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } imem_ld_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into one instruction word.
// Latency: word/word_ready are combinational with the completing byte.
// Backpressure: none; the caller qualifies bytes with accept.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_data,
    input  logic                     accept,
    input  logic                     last,
    input  logic                     clear,
    output logic [8*INSTR_BYTES-1:0] word,
    output logic                     word_ready
);

    logic [LANE_W-1:0]        lane_q;
    logic [8*INSTR_BYTES-1:0] asm_q;
    logic [8*INSTR_BYTES-1:0] merged;
    logic                     lane_full;

    // Drop the incoming byte into the lane selected by the lane counter.
    // Lanes above the current one are still zero because the assembly
    // register is cleared after every completed word.
    always_comb begin
        merged = asm_q;
        for (int k = 0; k < INSTR_BYTES; k++) begin
            if (lane_q == LANE_W'(k)) begin
                merged[8*k +: 8] = byte_data;
            end
        end
    end

    assign lane_full  = (lane_q == LANE_W'(INSTR_BYTES - 1));
    assign word_ready = accept & (lane_full | last);
    assign word       = merged;

    // Lane counter and partial-word register; restart on clear or word completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else if (clear || word_ready) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else if (accept) begin
            lane_q <= lane_q + 1'b1;
            asm_q  <= merged;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as sequential 32-bit word writes.
// Latency: word-completing byte accepted in cycle n -> mem_we in cycle n+1.
// Backpressure: byte_ready high only in LOAD (1 byte/cycle, no bubbles).
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    imem_ld_state_t    state_q;
    imem_ld_state_t    state_d;

    logic              accept;
    logic              pack_clear;
    logic              word_ready;
    logic [31:0]       packed_word;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    // Ready is a pure state decode so it stays high across word boundaries.
    assign byte_ready = (state_q == LOAD);
    assign accept     = byte_valid & byte_ready;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_data  (byte_data),
        .accept     (accept),
        .last       (byte_last),
        .clear      (pack_clear),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only from a resting state; the word that
    // carries byte_last ends the load cleanly even if it fills the last slot.
    always_comb begin
        state_d    = state_q;
        pack_clear = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LOAD;
                    pack_clear = 1'b1;
                end
            end
            LOAD: begin
                if (word_ready) begin
                    if (byte_last) begin
                        state_d = DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = ERR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next-address and word counters; cleared by start, advanced per word.
    // The address saturates on the last slot, so it never wraps within a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            count_q <= '0;
        end else if (pack_clear) begin
            addr_q  <= '0;
            count_q <= '0;
        end else if (word_ready) begin
            if (addr_q != LAST_ADDR) begin
                addr_q <= addr_q + 1'b1;
            end
            if (count_q != COUNT_MAX) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Write register: one-cycle strobe, address/data hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= word_ready;
            if (word_ready) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= packed_word;
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = count_q;
    assign core_hold  = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    // Small depth so both the clean full-memory load and the overflow are reachable.
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_w;
    logic [7:0]  stim_b[$];
    bit          stim_l[$];
    logic [31:0] shadow[DEPTH];
    logic [31:0] golden[DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Reference model: split the first nb stream bytes into words (4 bytes or
    // up to a last byte), stop at DEPTH words, and queue the expected writes.
    function automatic void model(input int nb, output int n_words,
                                  output bit e_done, output bit e_err, output int n_acc);
        int          lane = 0;
        logic [31:0] w    = '0;
        n_words = 0; e_done = 0; e_err = 0; n_acc = 0;
        for (int i = 0; i < nb && i < stim_b.size(); i++) begin
            if (e_done || e_err) break;
            w[8*lane +: 8] = stim_b[i];
            lane++;
            n_acc++;
            if (lane == 4 || stim_l[i]) begin
                exp_q.push_back('{addr: n_words, data: w});
                n_words++;
                w    = '0;
                lane = 0;
                if (stim_l[i]) e_done = 1;
                else if (n_words == DEPTH) e_err = 1;
            end
        end
    endfunction

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_we: addr=%0d data=0x%08h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(mon_w.addr));
                chk("wr_data", 64'(mem_wdata), 64'(mon_w.data));
            end
            shadow[mem_addr] = mem_wdata;
        end
    end

    function automatic void clear_stim();
        stim_b.delete();
        stim_l.delete();
    endfunction

    function automatic void add_byte(input logic [7:0] b, input bit l);
        stim_b.push_back(b);
        stim_l.push_back(l);
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_we"},    64'(mem_we), 0);
        chk({tag, "_addr"},  64'(mem_addr), 0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 0);
        chk({tag, "_wc"},    64'(word_count), 0);
        chk({tag, "_done"},  64'(done), 0);
        chk({tag, "_err"},   64'(error), 0);
        chk({tag, "_hold"},  64'(core_hold), 0);
        chk({tag, "_ready"}, 64'(byte_ready), 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_hold",  64'(core_hold), 1);
        chk("start_ready", 64'(byte_ready), 1);
        chk("start_done",  64'(done), 0);
        chk("start_err",   64'(error), 0);
        chk("start_wc",    64'(word_count), 0);
    endtask

    // Drives up to nb stream bytes; checks that mem_we follows exactly one cycle
    // after each word-completing byte. Returns at the negedge after the final
    // accepted byte (or after ready has stayed low for 8 cycles).
    task automatic run_stream(input int nb, input int gap_pct, input int start_at, output int n_acc);
        int idx = 0;
        int lane = 0;
        int idle = 0;
        bit exp_we = 0;
        n_acc = 0;
        while (idx < nb) begin
            @(negedge clk);
            chk("we_timing", 64'(mem_we), 64'(exp_we));
            exp_we = 0;
            start = (idx == start_at);
            if (byte_ready !== 1'b1) begin
                byte_valid = 1'b1;
                byte_data  = stim_b[idx];
                byte_last  = stim_l[idx];
                idle++;
                if (idle > 8) break;
            end else if ($urandom_range(99) < gap_pct) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                byte_last  = 1'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = stim_b[idx];
                byte_last  = stim_l[idx];
                idx++;
                n_acc++;
                lane++;
                if (lane == 4 || byte_last) begin
                    exp_we = 1;
                    lane   = 0;
                end
            end
        end
        @(negedge clk);
        chk("we_timing", 64'(mem_we), 64'(exp_we));
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        start      = 1'b0;
    endtask

    // Called in the cycle after the terminal byte: status must already be set,
    // concurrent with the final write; one cycle later address/data hold.
    task automatic check_end(input string tag, input bit e_done, input bit e_err, input int e_wc,
                             input int e_acc, input int acc, input int last_addr);
        chk({tag, "_done"},  64'(done), 64'(e_done));
        chk({tag, "_err"},   64'(error), 64'(e_err));
        chk({tag, "_wc"},    64'(word_count), 64'(e_wc));
        chk({tag, "_hold"},  64'(core_hold), 0);
        chk({tag, "_ready"}, 64'(byte_ready), 0);
        chk({tag, "_acc"},   64'(acc), 64'(e_acc));
        @(negedge clk);
        chk({tag, "_qempty"},   64'(exp_q.size()), 0);
        chk({tag, "_we_low"},   64'(mem_we), 0);
        chk({tag, "_addr_hold"}, 64'(mem_addr), 64'(last_addr));
    endtask

    initial begin
        int nw, ea, acc, bad;
        bit ed, ee;

        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Two full instructions.
        do_start();
        clear_stim();
        add_byte(8'h13, 0); add_byte(8'h00, 0); add_byte(8'h00, 0); add_byte(8'h00, 0);
        add_byte(8'h93, 0); add_byte(8'h00, 0); add_byte(8'h10, 0); add_byte(8'h00, 1);
        model(8, nw, ed, ee, ea);
        run_stream(8, 0, -1, acc);
        check_end("t1", 1, 0, 2, 8, acc, 1);
        chk("t1_w0", 64'(shadow[0]), 64'h0000_0013);
        chk("t1_w1", 64'(shadow[1]), 64'h0010_0093);

        // Short final word: upper lanes zero.
        do_start();
        clear_stim();
        for (int i = 1; i <= 6; i++) add_byte(8'(i), i == 6);
        model(6, nw, ed, ee, ea);
        run_stream(6, 0, -1, acc);
        check_end("t2", 1, 0, 2, 6, acc, 1);
        chk("t2_w0", 64'(shadow[0]), 64'h0403_0201);
        chk("t2_w1", 64'(shadow[1]), 64'h0000_0605);

        // Full memory with last on the final byte of the last slot, gap-free.
        do_start();
        clear_stim();
        for (int i = 0; i < 4 * DEPTH; i++) add_byte(8'($urandom), i == 4 * DEPTH - 1);
        model(4 * DEPTH, nw, ed, ee, ea);
        run_stream(4 * DEPTH, 0, -1, acc);
        check_end("t3a", 1, 0, DEPTH, 4 * DEPTH, acc, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            golden[i] = shadow[i];
            shadow[i] = '0;
        end

        // Same stream with random valid gaps must give the same image.
        do_start();
        model(4 * DEPTH, nw, ed, ee, ea);
        run_stream(4 * DEPTH, 40, -1, acc);
        check_end("t3b", 1, 0, DEPTH, 4 * DEPTH, acc, DEPTH - 1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (shadow[i] !== golden[i]) bad++;
        chk("t3_image_diffs", 64'(bad), 0);

        // Overflow: DEPTH+1 words with no last; byte 4*DEPTH+1 is refused.
        do_start();
        clear_stim();
        for (int i = 0; i < 4 * (DEPTH + 1); i++) add_byte(8'($urandom), 0);
        model(4 * (DEPTH + 1), nw, ed, ee, ea);
        chk("t4_model_err", 64'(ee), 1);
        run_stream(4 * (DEPTH + 1), 20, -1, acc);
        check_end("t4", 0, 1, DEPTH, 4 * DEPTH, acc, DEPTH - 1);

        // Restart after error writes address 0 again.
        do_start();
        clear_stim();
        add_byte(8'haa, 0); add_byte(8'hbb, 0); add_byte(8'hcc, 0); add_byte(8'hdd, 1);
        model(4, nw, ed, ee, ea);
        run_stream(4, 0, -1, acc);
        check_end("t4r", 1, 0, 1, 4, acc, 0);
        chk("t4r_w0", 64'(shadow[0]), 64'hddcc_bbaa);

        // Start during LOAD is ignored; reset after 2 bytes of the 4th word.
        do_start();
        clear_stim();
        for (int i = 0; i < 20; i++) add_byte(8'($urandom), 0);
        model(14, nw, ed, ee, ea);
        run_stream(14, 30, 6, acc);
        chk("t5_acc", 64'(acc), 14);
        rst_n      = 1'b0;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = stim_b[14];
        @(negedge clk);
        check_zero("t5_rst");
        rst_n      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_restart", 64'(core_hold), 0);
        repeat (3) @(negedge clk);
        chk("t5_qempty", 64'(exp_q.size()), 0);
        chk("t5_wc", 64'(word_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
